// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared core definitions for the decode/execute boundary: datapath width,
// writeback and ALU encodings, and the bundled E-stage control word.
package id_ex_pipe_reg_pkg;

    localparam int XLEN = 32;

    // Writeback result select. The fourth code is unused by the decoder but is
    // named so that any 2-bit value captured from decode is a legal member.
    typedef enum logic [1:0] {
        RESULT_ALU  = 2'b00,
        RESULT_MEM  = 2'b01,
        RESULT_PC4  = 2'b10,
        RESULT_RSVD = 2'b11
    } result_src_t;

    // ALU operation select, covering the full 3-bit code space.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_control_t;

    // All execute-stage control in one word so a bubble clears it in one step.
    typedef struct packed {
        logic         reg_write;
        result_src_t  result_src;
        logic         mem_write;
        logic         jump;
        logic         branch;
        alu_control_t alu_control;
        logic         alu_src;
    } ctrl_e_t;

    localparam ctrl_e_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; cleared only by reset.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one event per cycle that inc is high, holding once saturated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Decode/Execute pipeline register with hold, bubble insertion, validity
// tracking and saturating stall/bubble event counters.
module id_ex_pipe_reg #(
    parameter int XLEN  = id_ex_pipe_reg_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             stall_e,
    input  logic             flush_e,
    input  logic             valid_d,
    input  logic [XLEN-1:0]  pc_d,
    input  logic [XLEN-1:0]  pc_plus4_d,
    input  logic [XLEN-1:0]  rd_data1_d,
    input  logic [XLEN-1:0]  rd_data2_d,
    input  logic [XLEN-1:0]  imm_ext_d,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_d,
    input  logic             reg_write_d,
    input  logic             mem_write_d,
    input  logic             jump_d,
    input  logic             branch_d,
    input  logic             alu_src_d,
    input  logic [1:0]       result_src_d,
    input  logic [2:0]       alu_control_d,
    output logic             valid_e,
    output logic [XLEN-1:0]  pc_e,
    output logic [XLEN-1:0]  pc_plus4_e,
    output logic [XLEN-1:0]  rd_data1_e,
    output logic [XLEN-1:0]  rd_data2_e,
    output logic [XLEN-1:0]  imm_ext_e,
    output logic [4:0]       rs1_e,
    output logic [4:0]       rs2_e,
    output logic [4:0]       rd_e,
    output logic             reg_write_e,
    output logic             mem_write_e,
    output logic             jump_e,
    output logic             branch_e,
    output logic             alu_src_e,
    output logic [1:0]       result_src_e,
    output logic [2:0]       alu_control_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    import id_ex_pipe_reg_pkg::*;

    ctrl_e_t ctrl_d;
    ctrl_e_t ctrl_q;
    logic    stall_event;

    // Bundle the decode control bits into the E-stage control word.
    always_comb begin
        ctrl_d             = CTRL_BUBBLE;
        ctrl_d.reg_write   = reg_write_d;
        ctrl_d.result_src  = result_src_t'(result_src_d);
        ctrl_d.mem_write   = mem_write_d;
        ctrl_d.jump        = jump_d;
        ctrl_d.branch      = branch_d;
        ctrl_d.alu_control = alu_control_t'(alu_control_d);
        ctrl_d.alu_src     = alu_src_d;
    end

    // Stage register: flush clears everything (zero indices avoid false
    // forwarding and x0 writes), stall holds, otherwise capture decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_e    <= 1'b0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rd_data1_e <= '0;
            rd_data2_e <= '0;
            imm_ext_e  <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            ctrl_q     <= CTRL_BUBBLE;
        end else if (flush_e) begin
            valid_e    <= 1'b0;
            pc_e       <= '0;
            pc_plus4_e <= '0;
            rd_data1_e <= '0;
            rd_data2_e <= '0;
            imm_ext_e  <= '0;
            rs1_e      <= '0;
            rs2_e      <= '0;
            rd_e       <= '0;
            ctrl_q     <= CTRL_BUBBLE;
        end else if (!stall_e) begin
            valid_e    <= valid_d;
            pc_e       <= pc_d;
            pc_plus4_e <= pc_plus4_d;
            rd_data1_e <= rd_data1_d;
            rd_data2_e <= rd_data2_d;
            imm_ext_e  <= imm_ext_d;
            rs1_e      <= rs1_d;
            rs2_e      <= rs2_d;
            rd_e       <= rd_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign reg_write_e   = ctrl_q.reg_write;
    assign result_src_e  = ctrl_q.result_src;
    assign mem_write_e   = ctrl_q.mem_write;
    assign jump_e        = ctrl_q.jump;
    assign branch_e      = ctrl_q.branch;
    assign alu_control_e = ctrl_q.alu_control;
    assign alu_src_e     = ctrl_q.alu_src;

    // A stall only counts when it is not overridden by a flush.
    assign stall_event = stall_e & ~flush_e;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (stall_event),
        .count   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (flush_e),
        .count   (bubble_cnt)
    );

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for the Decode/Execute pipeline register, built with
// narrow counters so saturation is reachable quickly.
module tb_id_ex_pipe_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset_n;
    logic             stall_e, flush_e, valid_d;
    logic [XLEN-1:0]  pc_d, pc_plus4_d, rd_data1_d, rd_data2_d, imm_ext_d;
    logic [4:0]       rs1_d, rs2_d, rd_d;
    logic             reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0]       result_src_d;
    logic [2:0]       alu_control_d;
    logic             valid_e;
    logic [XLEN-1:0]  pc_e, pc_plus4_e, rd_data1_e, rd_data2_e, imm_ext_e;
    logic [4:0]       rs1_e, rs2_e, rd_e;
    logic             reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e;
    logic [1:0]       result_src_e;
    logic [2:0]       alu_control_e;
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;

    id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e),
        .valid_d(valid_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
        .rd_data1_d(rd_data1_d), .rd_data2_d(rd_data2_d), .imm_ext_d(imm_ext_d),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .mem_write_d(mem_write_d), .jump_d(jump_d),
        .branch_d(branch_d), .alu_src_d(alu_src_d),
        .result_src_d(result_src_d), .alu_control_d(alu_control_d),
        .valid_e(valid_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
        .rd_data1_e(rd_data1_e), .rd_data2_e(rd_data2_e), .imm_ext_e(imm_ext_e),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .jump_e(jump_e),
        .branch_e(branch_e), .alu_src_e(alu_src_e),
        .result_src_e(result_src_e), .alu_control_e(alu_control_e),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    // Snapshot of every DUT output, used both for the model and observation.
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc, pc4, d1, d2, imm;
        logic [4:0]       rs1, rs2, rd;
        logic             reg_write;
        logic [1:0]       result_src;
        logic             mem_write, jump, branch;
        logic [2:0]       alu_control;
        logic             alu_src;
        logic [CNT_W-1:0] scnt, bcnt;
    } snap_t;

    localparam int CHK_W = $bits(snap_t);

    snap_t model;
    snap_t expQ[$];
    int    checks;
    int    errors;

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic snap_t observe();
        snap_t s;
        s.valid = valid_e;       s.pc = pc_e;           s.pc4 = pc_plus4_e;
        s.d1 = rd_data1_e;       s.d2 = rd_data2_e;     s.imm = imm_ext_e;
        s.rs1 = rs1_e;           s.rs2 = rs2_e;         s.rd = rd_e;
        s.reg_write = reg_write_e; s.result_src = result_src_e;
        s.mem_write = mem_write_e; s.jump = jump_e;     s.branch = branch_e;
        s.alu_control = alu_control_e; s.alu_src = alu_src_e;
        s.scnt = stall_cnt;      s.bcnt = bubble_cnt;
        return s;
    endfunction

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    task automatic checkOutput(input string tag, input logic [CHK_W-1:0] obs,
                               input logic [CHK_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic randomizeInputs();
        valid_d       = 1'($urandom);
        pc_d          = $urandom;
        pc_plus4_d    = $urandom;
        rd_data1_d    = $urandom;
        rd_data2_d    = $urandom;
        imm_ext_d     = $urandom;
        rs1_d         = 5'($urandom);
        rs2_d         = 5'($urandom);
        rd_d          = 5'($urandom);
        reg_write_d   = 1'($urandom);
        mem_write_d   = 1'($urandom);
        jump_d        = 1'($urandom);
        branch_d      = 1'($urandom);
        alu_src_d     = 1'($urandom);
        result_src_d  = 2'($urandom);
        alu_control_d = 3'($urandom);
    endtask

    // Drive one cycle of control, predict the E stage, then compare after the edge.
    task automatic applyStimulus(input logic f, input logic s, input string tag);
        snap_t nxt;
        flush_e = f;
        stall_e = s;
        if (f) begin
            nxt      = '0;
            nxt.scnt = model.scnt;
            nxt.bcnt = satInc(model.bcnt);
        end else if (s) begin
            nxt      = model;
            nxt.scnt = satInc(model.scnt);
        end else begin
            nxt.valid = valid_d;       nxt.pc = pc_d;          nxt.pc4 = pc_plus4_d;
            nxt.d1 = rd_data1_d;       nxt.d2 = rd_data2_d;    nxt.imm = imm_ext_d;
            nxt.rs1 = rs1_d;           nxt.rs2 = rs2_d;        nxt.rd = rd_d;
            nxt.reg_write = reg_write_d; nxt.result_src = result_src_d;
            nxt.mem_write = mem_write_d; nxt.jump = jump_d;    nxt.branch = branch_d;
            nxt.alu_control = alu_control_d; nxt.alu_src = alu_src_d;
            nxt.scnt = model.scnt;     nxt.bcnt = model.bcnt;
        end
        expQ.push_back(nxt);
        model = nxt;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: scoreboard empty", tag);
        end else begin
            checkOutput(tag, observe(), expQ.pop_front());
        end
    endtask

    // Assert reset between edges and confirm outputs clear with no clock edge.
    task automatic pulseReset(input string tag);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        model = '0;
        expQ.delete();
        checkOutput(tag, observe(), '0);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        model   = '0;
        reset_n = 1'b0;
        stall_e = 1'b0;
        flush_e = 1'b0;
        randomizeInputs();
        #2;
        checkOutput("reset_init", observe(), '0);
        @(negedge clk);
        reset_n = 1'b1;

        // Normal load of a known instruction.
        randomizeInputs();
        rd_data2_d = 32'hDEADBEEF; rs2_d = 5'd5; rd_d = 5'd7;
        reg_write_d = 1'b1; valid_d = 1'b1;
        applyStimulus(1'b0, 1'b0, "load");
        checkOutput("load_rd_data2", CHK_W'(rd_data2_e), CHK_W'(32'hDEADBEEF));
        checkOutput("load_rs2", CHK_W'(rs2_e), CHK_W'(5'd5));
        checkOutput("load_rd", CHK_W'(rd_e), CHK_W'(5'd7));
        checkOutput("load_reg_write", CHK_W'(reg_write_e), CHK_W'(1'b1));
        checkOutput("load_valid", CHK_W'(valid_e), CHK_W'(1'b1));

        // Three stalls with changing decode inputs.
        for (int i = 0; i < 3; i++) begin
            randomizeInputs();
            applyStimulus(1'b0, 1'b1, "stall");
            checkOutput("stall_hold_d2", CHK_W'(rd_data2_e), CHK_W'(32'hDEADBEEF));
        end
        checkOutput("stall_cnt3", CHK_W'(stall_cnt), CHK_W'(4'd3));

        // Flush while holding rd=7 with reg_write.
        randomizeInputs();
        applyStimulus(1'b1, 1'b0, "flush");
        checkOutput("flush_rd", CHK_W'(rd_e), CHK_W'(5'd0));
        checkOutput("flush_reg_write", CHK_W'(reg_write_e), CHK_W'(1'b0));
        checkOutput("flush_valid", CHK_W'(valid_e), CHK_W'(1'b0));
        checkOutput("flush_bubble_cnt", CHK_W'(bubble_cnt), CHK_W'(4'd1));

        // Simultaneous stall and flush: flush wins.
        randomizeInputs();
        valid_d = 1'b1; rd_d = 5'd9;
        applyStimulus(1'b0, 1'b0, "reload");
        randomizeInputs();
        applyStimulus(1'b1, 1'b1, "stall_flush");
        checkOutput("sf_bubble_cnt", CHK_W'(bubble_cnt), CHK_W'(4'd2));
        checkOutput("sf_stall_cnt", CHK_W'(stall_cnt), CHK_W'(4'd3));
        checkOutput("sf_rd", CHK_W'(rd_e), CHK_W'(5'd0));

        // Random mix of load, stall, flush and both.
        for (int i = 0; i < 40; i++) begin
            int r;
            randomizeInputs();
            r = $urandom_range(0, 7);
            applyStimulus(r == 0 || r == 3, r == 1 || r == 2 || r == 3, "random");
        end

        // Reset in the middle of a stall, then a normal first edge.
        randomizeInputs();
        stall_e = 1'b1;
        pulseReset("reset_mid_stall");
        randomizeInputs();
        applyStimulus(1'b0, 1'b0, "post_reset_load");
        checkOutput("post_reset_stall_cnt", CHK_W'(stall_cnt), CHK_W'(4'd0));

        // Twenty stalls saturate the 4-bit counter without wrapping.
        for (int i = 0; i < 20; i++) begin
            randomizeInputs();
            applyStimulus(1'b0, 1'b1, "sat");
        end
        checkOutput("sat_stall_cnt", CHK_W'(stall_cnt), CHK_W'(4'hF));

        // Twenty flushes saturate the bubble counter as well.
        for (int i = 0; i < 20; i++) begin
            randomizeInputs();
            applyStimulus(1'b1, 1'($urandom), "sat_bubble");
        end
        checkOutput("sat_bubble_cnt", CHK_W'(bubble_cnt), CHK_W'(4'hF));

        // Reset in the middle of a flush, then a normal load.
        randomizeInputs();
        flush_e = 1'b1;
        pulseReset("reset_mid_flush");
        randomizeInputs();
        applyStimulus(1'b0, 1'b0, "post_flush_reset_load");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
